// File: rtl/four_digit_scroller.sv
// four_digit_scroller
//   Drives a 4-digit common-anode display through an external 4-bit to
//   7-segment decoder. Holds a 16-entry message of 4-bit characters and
//   shows a 4-character window of it, scrolling the window one position
//   per scroll period. Each digit slot is split into setup / on / on /
//   guard sub-phases so the decoder input settles before and after an
//   anode is lit (anti-ghosting).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   scroll_en  in   1 = scroll counter advances, 0 = it holds
//   msg_we     in   message write strobe
//   msg_addr   in   [3:0] message entry to write
//   msg_data   in   [3:0] character to write
//   an         out  [3:0] anode enables, active-low, an[3] = leftmost
//   char       out  [3:0] character code for the decoder
//   pos        out  [3:0] committed scroll offset (index shown on an[3])
module four_digit_scroller #(
    parameter int SCAN_DIV      = 16,
    parameter int SCROLL_PERIOD = 25_000_000,
    parameter int SCROLL_W      = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scroll_en,
    input  logic       msg_we,
    input  logic [3:0] msg_addr,
    input  logic [3:0] msg_data,
    output logic [3:0] an,
    output logic [3:0] char,
    output logic [3:0] pos
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]          mem [16];
    logic [DIV_W-1:0]    div_cnt;
    logic [3:0]          phase;
    logic [3:0]          pend;
    logic [SCROLL_W-1:0] scroll_cnt;

    logic       tick;
    logic       scroll_wrap;
    logic [3:0] phase_nxt;
    logic [1:0] slot;
    logic [1:0] sub;
    logic [3:0] base;
    logic [3:0] rd_addr;
    logic [3:0] an_nxt;
    logic [3:0] char_nxt;

    assign tick        = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign scroll_wrap = (scroll_cnt == SCROLL_W'(SCROLL_PERIOD - 1));

    // Everything below describes what an/char become on the next tick,
    // derived from the phase being entered.
    always_comb begin
        phase_nxt = phase + 4'd1;
        slot      = phase_nxt[3:2];
        sub       = phase_nxt[1:0];
        // Entering phase 0 is the frame commit edge: pos is loaded with
        // pend on the same edge, so slot 0's setup must already use pend
        // to keep the whole frame on a single offset.
        base      = (phase_nxt == 4'd0) ? pend : pos;
        rd_addr   = base + {2'b00, slot};          // 4-bit wrap, 15 -> 0
        an_nxt    = 4'b1111;
        char_nxt  = char;
        case (sub)
            2'b00:        char_nxt = mem[rd_addr]; // setup, anodes dark
            2'b01, 2'b10: an_nxt   = ~(4'b1000 >> slot);
            default:      an_nxt   = 4'b1111;      // guard gap
        endcase
    end

    // Message memory; reads above see the pre-write contents on the
    // same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
        end else if (msg_we) begin
            mem[msg_addr] <= msg_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            phase      <= '0;
            an         <= 4'b1111;
            char       <= '0;
            pos        <= '0;
            pend       <= '0;
            scroll_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

            if (tick) begin
                phase <= phase_nxt;
                an    <= an_nxt;
                char  <= char_nxt;
                // Old pend is committed; a pend bump on this same edge
                // waits for the next frame.
                if (phase_nxt == 4'd0) pos <= pend;
            end

            // Holding (not clearing) while disabled lets a paused scroll
            // resume exactly where it stopped.
            if (scroll_en) begin
                if (scroll_wrap) begin
                    scroll_cnt <= '0;
                    pend       <= pend + 4'd1;
                end else begin
                    scroll_cnt <= scroll_cnt + SCROLL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_four_digit_scroller.sv
// Directed bench for four_digit_scroller with SCAN_DIV = 2 and
// SCROLL_PERIOD = 40. "Cycle N" means N rising edges after reset was
// released; all sampling is on the falling edge.
module tb_four_digit_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic       scroll_en;
    logic       msg_we;
    logic [3:0] msg_addr;
    logic [3:0] msg_data;
    logic [3:0] an;
    logic [3:0] char;
    logic [3:0] pos;

    int checks = 0;
    int errors = 0;
    int cyc_now = 0;

    four_digit_scroller #(
        .SCAN_DIV     (2),
        .SCROLL_PERIOD(40),
        .SCROLL_W     (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scroll_en(scroll_en),
        .msg_we   (msg_we),
        .msg_addr (msg_addr),
        .msg_data (msg_data),
        .an       (an),
        .char     (char),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_now);
        end
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc_now++;
        end
    endtask

    task automatic goto_cyc(input int c);
        if (c > cyc_now) adv(c - cyc_now);
    endtask

    // One-cycle write; the write lands on the next rising edge.
    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        msg_we   = 1'b1;
        msg_addr = a;
        msg_data = d;
        adv(1);
        msg_we   = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset   = 1'b0;
        cyc_now = 0;
    endtask

    initial begin
        reset     = 1'b1;
        scroll_en = 1'b0;
        msg_we    = 1'b0;
        msg_addr  = '0;
        msg_data  = '0;
        repeat (3) @(posedge clk);
        release_reset();

        // 1. reset state and first frame
        chk("rst_an",   an,   4'b1111);
        chk("rst_char", char, 4'h0);
        chk("rst_pos",  pos,  4'h0);
        goto_cyc(1);
        chk("c1_an",    an,   4'b1111);
        goto_cyc(2);
        chk("c2_an",    an,   4'b0111);
        chk("c2_char",  char, 4'h0);
        goto_cyc(8);
        chk("c8_an",    an,   4'b1111);
        chk("c8_char",  char, 4'h1);
        goto_cyc(10);
        chk("c10_an",   an,   4'b1011);
        chk("c10_char", char, 4'h1);

        // 2a. write on the slot-2 setup edge (edge 16): old value shown
        goto_cyc(15);
        wr(4'd2, 4'hA);
        goto_cyc(18);
        chk("c18_an",   an,   4'b1101);
        chk("c18_old",  char, 4'h2);
        goto_cyc(26);
        chk("c26_an",   an,   4'b1110);
        chk("c26_char", char, 4'h3);

        // 2b. phase-0 write in frame 2; both writes visible this frame
        goto_cyc(32);
        wr(4'd3, 4'hD);
        goto_cyc(50);
        chk("c50_an",   an,   4'b1101);
        chk("c50_new",  char, 4'hA);
        goto_cyc(58);
        chk("c58_an",   an,   4'b1110);
        chk("c58_new",  char, 4'hD);

        // restore identity contents before frame 3
        goto_cyc(60);
        wr(4'd2, 4'h2);
        wr(4'd3, 4'h3);

        // 3. scroll: enabled at cycle 64, first wrap on edge 104
        goto_cyc(64);
        scroll_en = 1'b1;
        goto_cyc(103);
        chk("pend_103", dut.pend, 4'h0);
        goto_cyc(104);
        chk("pend_104", dut.pend, 4'h1);
        goto_cyc(127);
        chk("pos_127",  pos, 4'h0);
        goto_cyc(128);
        chk("pos_128",  pos, 4'h1);
        goto_cyc(130);
        chk("f_s0", char, 4'h1);
        chk("f_a0", an,   4'b0111);
        goto_cyc(138);
        chk("f_s1", char, 4'h2);
        goto_cyc(146);
        chk("f_s2", char, 4'h3);
        goto_cyc(154);
        chk("f_s3", char, 4'h4);
        chk("f_a3", an,   4'b1110);

        // 4. wrap-around: pend = 14 at 624, committed at 640
        goto_cyc(641);
        chk("pos_641", pos, 4'hE);
        goto_cyc(642);
        chk("w_s0", char, 4'hE);
        goto_cyc(650);
        chk("w_s1", char, 4'hF);
        goto_cyc(658);
        chk("w_s2", char, 4'h0);
        goto_cyc(666);
        chk("w_s3", char, 4'h1);

        // 5. pause at scroll_cnt = 20 for 100 cycles
        goto_cyc(684);
        chk("sc_684", dut.scroll_cnt, 6'd20);
        scroll_en = 1'b0;
        goto_cyc(784);
        chk("sc_hold",  dut.scroll_cnt, 6'd20);
        chk("pend_hold", dut.pend, 4'hF);
        scroll_en = 1'b1;
        goto_cyc(803);
        chk("pend_803", dut.pend, 4'hF);
        goto_cyc(804);
        chk("pend_804", dut.pend, 4'h0);

        // 6. writes, then reset during phase 6 (cycles 812-813)
        goto_cyc(805);
        wr(4'd5, 4'h7);
        wr(4'd0, 4'h9);
        goto_cyc(812);
        chk("pre_pos",  pos,  4'hF);
        chk("pre_an",   an,   4'b1011);
        chk("pre_char", char, 4'h9);
        reset = 1'b1;
        #1;
        chk("ar_an",   an,   4'b1111);
        chk("ar_char", char, 4'h0);
        chk("ar_pos",  pos,  4'h0);
        chk("ar_mem0", dut.mem[0], 4'h0);
        chk("ar_mem5", dut.mem[5], 4'h5);
        chk("ar_pend", dut.pend, 4'h0);
        repeat (2) @(posedge clk);
        release_reset();
        goto_cyc(1);
        chk("r2_c1_an", an, 4'b1111);
        goto_cyc(2);
        chk("r2_c2_an", an, 4'b0111);
        goto_cyc(8);
        chk("r2_c8_char", char, 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
